i2c_xfer_ctrl: RTL and testbench
================================

# i2c_xfer_ctrl

Transaction sequencer for the I2C controller. Sits between the CSR-side command logic and the byte-level I2C engine. It turns one command (7-bit device address, direction, byte count) into the engine op sequence START, address byte, N data bytes, STOP. It streams write bytes in and read bytes out, and reports completion and NACK status.

## Interface
Parameters:
- LEN_W, 5, width of byte-count field; max transfer 2**LEN_W-1 bytes.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous, active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high only in IDLE; command accepted on cmd_valid_i & cmd_ready_o.
- cmd_dev_addr_i  in  7  target device address.
- cmd_rw_i  in  1  1 = read, 0 = write.
- cmd_len_i  in  LEN_W  data byte count; 0 = address-only probe.
- wr_data_i  in  8  write byte.
- wr_valid_i  in  1  write byte available.
- wr_ready_o  out  1  controller takes a write byte.
- rd_data_o  out  8  read byte.
- rd_valid_o  out  1  one-cycle pulse; no backpressure.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at transaction end.
- err_nack_o  out  1  valid while done_o; 1 = address or data byte NACKed.
- bc_op_o  out  2  engine op: 00 START, 01 WRITE, 10 READ, 11 STOP.
- bc_valid_o  out  1  op request.
- bc_ready_i  in  1  engine accepts op on bc_valid_o & bc_ready_i.
- bc_wdata_o  out  8  byte for WRITE op.
- bc_last_o  out  1  for READ: master sends NACK after this byte.
- bc_done_i  in  1  one-cycle pulse when an accepted op completes.
- bc_ack_i  in  1  slave ACK, valid with bc_done_i for WRITE.
- bc_rdata_i  in  8  received byte, valid with bc_done_i for READ.

## Operation
- States: IDLE, START, ADDR, WLOAD, WDATA, RDATA, STOP, DONE.
- Engine-op states (START, ADDR, WDATA, RDATA, STOP) each have two phases:
  - issue: bc_valid_o high, op and data stable until bc_ready_i.
  - wait: bc_valid_o low until bc_done_i.
- IDLE: on command accept, latch address, rw and len into the remaining-count register, clear the err flag, go to START.
- START: after bc_done_i, go to ADDR.
- ADDR: bc_wdata_o = {dev_addr, rw}. On bc_done_i:
  - !bc_ack_i: set err, go to STOP.
  - else remaining==0: go to STOP.
  - else rw=1: go to RDATA.
  - else: go to WLOAD.
- WLOAD: wr_ready_o=1. On wr_valid_i, latch wr_data_i and go to WDATA.
- WDATA: on bc_done_i, decrement remaining.
  - !bc_ack_i: set err, go to STOP; remaining bytes are not consumed.
  - else remaining (after decrement) 0: go to STOP.
  - else: go to WLOAD.
- RDATA: bc_last_o = (remaining==1). On bc_done_i:
  - register bc_rdata_i into rd_data_o and pulse rd_valid_o next cycle;
  - decrement remaining; go to STOP when it reaches 0, else repeat RDATA.
- STOP: on bc_done_i, go to DONE.
- DONE: done_o=1 and err_nack_o=err for one cycle, then IDLE.
- Ignored inputs:
  - bc_done_i outside a wait phase;
  - bc_ack_i on START/STOP/READ;
  - cmd_valid_i while busy.
- Count arithmetic is LEN_W-bit unsigned. Decrement happens only on bc_done_i, so the count never wraps below 0.

## Timing
- Reset values:
  - state IDLE; cmd_ready_o=1 (decoded from IDLE);
  - busy_o, done_o, err_nack_o, rd_valid_o, wr_ready_o, bc_valid_o, bc_last_o = 0;
  - bc_op_o=00; bc_wdata_o, rd_data_o = 0.
- Reset mid-transaction: return to IDLE next edge, no STOP issued (the engine shares rst_i), no done_o.
- Command accept at edge N: bc_valid_o with START from cycle N+1.
- Op accepted at edge M (bc_valid_o & bc_ready_i): bc_valid_o low from cycle M+1.
  - If the engine keeps bc_ready_i high, acceptance happens in the first issue cycle.
- bc_done_i at edge K: next op's bc_valid_o high from cycle K+1.
- Read: bc_done_i at edge K gives rd_valid_o high in cycle K+1, exactly one cycle.
- Write: wr_ready_o is high for at least the cycle after entering WLOAD and stays high until wr_valid_i is seen.
  - A byte waiting with wr_valid_i already high is taken on the first WLOAD cycle.
- STOP bc_done_i at edge S: done_o in cycle S+1, cmd_ready_o from cycle S+2.
- A new command can be accepted in the cycle cmd_ready_o returns high.

## Test plan
- Write addr 0x50, len 2, bytes 0xA5, 0x3C, engine always ACKs:
  - ops START, WRITE 0xA0, WRITE 0xA5, WRITE 0x3C, STOP;
  - exactly 2 wr_ready_o handshakes; done_o with err_nack_o=0.
- Read addr 0x68, len 3, engine returns 0x11, 0x22, 0x33:
  - ops START, WRITE 0xD1, READ x3, with bc_last_o=1 only on the third;
  - rd_valid_o pulses 0x11, 0x22, 0x33; err_nack_o=0.
- Probe addr 0x7F, len 0, address NACK:
  - START, WRITE 0xFE, STOP; done_o with err_nack_o=1; wr_ready_o never asserted.
- Write len 3 with NACK on the second data byte:
  - STOP follows immediately; only 2 bytes consumed; err_nack_o=1.
- Backpressure: bc_ready_i low for 4 cycles on each op and wr_valid_i delayed 3 cycles:
  - op/data stable while bc_valid_o is high; sequence and result identical to the first scenario.
- rst_i pulsed during the RDATA wait:
  - next cycle all outputs at reset values; then a fresh write command completes normally.

Source files
------------

// File: rtl/i2c_xfer_ctrl_if.sv
// i2c_xfer_ctrl_if
//   Bundles the three handshakes of the transaction sequencer:
//     - command channel from the CSR side (cmd_*)
//     - write/read byte streams (wr_*, rd_*) plus completion status
//     - byte-engine op channel (bc_*)
//   Signal names keep their _i/_o suffixes as seen from the sequencer.
//   modport master : the sequencer itself
//   modport slave  : everything around it (CSR logic, data FIFOs, engine)
interface i2c_xfer_ctrl_if #(
  parameter int LEN_W = 5
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [6:0]       cmd_dev_addr_i;
  logic             cmd_rw_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic [7:0]       wr_data_i;
  logic             wr_valid_i;
  logic             wr_ready_o;
  logic [7:0]       rd_data_o;
  logic             rd_valid_o;
  logic             busy_o;
  logic             done_o;
  logic             err_nack_o;
  logic [1:0]       bc_op_o;
  logic             bc_valid_o;
  logic             bc_ready_i;
  logic [7:0]       bc_wdata_o;
  logic             bc_last_o;
  logic             bc_done_i;
  logic             bc_ack_i;
  logic [7:0]       bc_rdata_i;

  modport master (
    input  cmd_valid_i, cmd_dev_addr_i, cmd_rw_i, cmd_len_i,
    input  wr_data_i, wr_valid_i,
    input  bc_ready_i, bc_done_i, bc_ack_i, bc_rdata_i,
    output cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o,
    output busy_o, done_o, err_nack_o,
    output bc_op_o, bc_valid_o, bc_wdata_o, bc_last_o
  );

  modport slave (
    output cmd_valid_i, cmd_dev_addr_i, cmd_rw_i, cmd_len_i,
    output wr_data_i, wr_valid_i,
    output bc_ready_i, bc_done_i, bc_ack_i, bc_rdata_i,
    input  cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o,
    input  busy_o, done_o, err_nack_o,
    input  bc_op_o, bc_valid_o, bc_wdata_o, bc_last_o
  );
endinterface

// File: rtl/i2c_xfer_ctrl.sv
// i2c_xfer_ctrl
//   I2C transaction sequencer. Turns one command (7-bit address, rw, byte
//   count) into the byte-engine op sequence START, address, N data, STOP,
//   streams write bytes in / read bytes out and reports done + NACK status.
// Ports:
//   clk_i  - single clock
//   rst_i  - synchronous active-high reset
//   bus    - i2c_xfer_ctrl_if.master: cmd_*, wr_*, rd_*, status, bc_*
module i2c_xfer_ctrl #(
  parameter int LEN_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  i2c_xfer_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WLOAD, S_WDATA, S_RDATA, S_STOP, S_DONE
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  state_t           r_state;
  logic [6:0]       r_addr;
  logic             r_rw;
  logic [LEN_W-1:0] r_rem;
  logic             r_err;
  logic             r_bc_valid;
  logic [1:0]       r_bc_op;
  logic [7:0]       r_bc_wdata;
  logic             r_bc_last;
  logic             r_wr_ready;
  logic             r_rd_valid;
  logic [7:0]       r_rd_data;
  logic             r_done;
  logic             r_err_nack;

  // Every engine-op state enters with r_bc_valid set, so "valid low" inside
  // one of those states is exactly its wait phase; bc_done_i elsewhere is
  // ignored.
  logic             w_op_done;
  logic [LEN_W-1:0] w_rem_dec;

  assign w_op_done = !r_bc_valid && bus.bc_done_i;
  assign w_rem_dec = r_rem - LEN_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_rem      <= '0;
      r_err      <= 1'b0;
      r_bc_valid <= 1'b0;
      r_bc_op    <= OP_START;
      r_bc_wdata <= '0;
      r_bc_last  <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
      r_err_nack <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err_nack <= 1'b0;
      // Drop the request the cycle after the engine takes it.
      if (r_bc_valid && bus.bc_ready_i) r_bc_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid_i) begin
            r_addr     <= bus.cmd_dev_addr_i;
            r_rw       <= bus.cmd_rw_i;
            r_rem      <= bus.cmd_len_i;
            r_err      <= 1'b0;
            r_state    <= S_START;
            r_bc_valid <= 1'b1;
            r_bc_op    <= OP_START;
            r_bc_last  <= 1'b0;
          end
        end
        S_START: begin
          if (w_op_done) begin
            r_state    <= S_ADDR;
            r_bc_valid <= 1'b1;
            r_bc_op    <= OP_WRITE;
            r_bc_wdata <= {r_addr, r_rw};
          end
        end
        S_ADDR: begin
          if (w_op_done) begin
            if (!bus.bc_ack_i || r_rem == '0) begin
              r_err      <= !bus.bc_ack_i;
              r_state    <= S_STOP;
              r_bc_valid <= 1'b1;
              r_bc_op    <= OP_STOP;
            end else if (r_rw) begin
              r_state    <= S_RDATA;
              r_bc_valid <= 1'b1;
              r_bc_op    <= OP_READ;
              r_bc_last  <= (r_rem == LEN_W'(1));
            end else begin
              r_state    <= S_WLOAD;
              r_wr_ready <= 1'b1;
            end
          end
        end
        S_WLOAD: begin
          // wr_ready is already high on the first WLOAD cycle, so a byte
          // that is waiting is taken immediately.
          if (bus.wr_valid_i) begin
            r_wr_ready <= 1'b0;
            r_state    <= S_WDATA;
            r_bc_valid <= 1'b1;
            r_bc_op    <= OP_WRITE;
            r_bc_wdata <= bus.wr_data_i;
          end
        end
        S_WDATA: begin
          if (w_op_done) begin
            r_rem <= w_rem_dec;
            if (!bus.bc_ack_i || w_rem_dec == '0) begin
              // On NACK the unsent bytes stay in the source.
              r_err      <= !bus.bc_ack_i;
              r_state    <= S_STOP;
              r_bc_valid <= 1'b1;
              r_bc_op    <= OP_STOP;
            end else begin
              r_state    <= S_WLOAD;
              r_wr_ready <= 1'b1;
            end
          end
        end
        S_RDATA: begin
          if (w_op_done) begin
            r_rd_data  <= bus.bc_rdata_i;
            r_rd_valid <= 1'b1;
            r_rem      <= w_rem_dec;
            r_bc_valid <= 1'b1;
            if (w_rem_dec == '0) begin
              r_state   <= S_STOP;
              r_bc_op   <= OP_STOP;
              r_bc_last <= 1'b0;
            end else begin
              r_bc_op   <= OP_READ;
              r_bc_last <= (w_rem_dec == LEN_W'(1));
            end
          end
        end
        S_STOP: begin
          if (w_op_done) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_err_nack <= r_err;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = (r_state == S_IDLE);
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.wr_ready_o  = r_wr_ready;
  assign bus.rd_data_o   = r_rd_data;
  assign bus.rd_valid_o  = r_rd_valid;
  assign bus.done_o      = r_done;
  assign bus.err_nack_o  = r_err_nack;
  assign bus.bc_op_o     = r_bc_op;
  assign bus.bc_valid_o  = r_bc_valid;
  assign bus.bc_wdata_o  = r_bc_wdata;
  assign bus.bc_last_o   = r_bc_last;

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
module tb_i2c_xfer_ctrl;
  localparam int LEN_W = 5;
  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;
  // Sentinel expected value used when a scoreboard queue is unexpectedly empty.
  localparam logic [31:0] NONE = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_xfer_ctrl_if #(.LEN_W(LEN_W)) bus ();
  i2c_xfer_ctrl #(.LEN_W(LEN_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected op stream {op, wdata-or-0, last-or-0}, read bytes, done status.
  logic [10:0] exp_op_q[$];
  logic [7:0]  exp_rd_q[$];
  logic        exp_done_q[$];
  // Engine responses and write-byte source.
  logic        eng_ack_q[$];
  logic [7:0]  eng_rd_q[$];
  logic [7:0]  wr_src_q[$];

  int bp_cycles = 0;
  int wr_delay  = 0;
  int n_done = 0, n_wr_hs = 0, n_wr_rdy = 0, n_rd_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine model, write-byte source and output monitors.
  initial begin : env
    int pend, vcnt, wdly;
    logic wr_hs, stall_prev, prev_done, resp_ack;
    logic [7:0] resp_data;
    logic [10:0] held, obs;
    pend = 0; vcnt = 0; wdly = 0; wr_hs = 0; stall_prev = 0; prev_done = 0;
    resp_ack = 1; resp_data = 0; held = 0; obs = 0;
    bus.bc_ready_i = 0; bus.bc_done_i = 0; bus.bc_ack_i = 0; bus.bc_rdata_i = 0;
    bus.wr_valid_i = 0; bus.wr_data_i = 0;
    forever begin
      @(negedge clk);
      wr_hs = 1'b0;
      if (rst) begin
        pend = 0; stall_prev = 0; prev_done = 0;
      end else begin
        obs = {bus.bc_op_o, (bus.bc_op_o == OP_WRITE) ? bus.bc_wdata_o : 8'h00,
               (bus.bc_op_o == OP_READ) ? bus.bc_last_o : 1'b0};
        if (stall_prev) chk("bc_hold", 32'({bus.bc_valid_o, obs}), 32'({1'b1, held}));
        stall_prev = bus.bc_valid_o && !bus.bc_ready_i;
        held = obs;
        if (bus.bc_valid_o && bus.bc_ready_i) begin
          if (exp_op_q.size() > 0) chk("bc_op", 32'(obs), 32'(exp_op_q.pop_front()));
          else chk("bc_op_extra", 32'(obs), NONE);
          resp_ack = 1'b1; resp_data = 8'h00;
          if (bus.bc_op_o == OP_WRITE && eng_ack_q.size() > 0) resp_ack = eng_ack_q.pop_front();
          if (bus.bc_op_o == OP_READ) begin
            n_rd_acc++;
            if (eng_rd_q.size() > 0) resp_data = eng_rd_q.pop_front();
          end
          pend = 2;
        end
        if (prev_done) chk("rdy_after_done", 32'({bus.cmd_ready_o, bus.busy_o}), 32'(2'b10));
        prev_done = bus.done_o;
        if (bus.done_o) begin
          n_done++;
          if (exp_done_q.size() > 0) chk("err_nack", 32'(bus.err_nack_o), 32'(exp_done_q.pop_front()));
          else chk("done_extra", 32'(bus.err_nack_o), NONE);
        end
        if (bus.rd_valid_o) begin
          if (exp_rd_q.size() > 0) chk("rd_data", 32'(bus.rd_data_o), 32'(exp_rd_q.pop_front()));
          else chk("rd_extra", 32'(bus.rd_data_o), NONE);
        end
        if (bus.wr_ready_o) n_wr_rdy++;
        wr_hs = bus.wr_valid_i && bus.wr_ready_o;
        if (wr_hs) n_wr_hs++;
      end
      @(posedge clk); #1;
      bus.bc_done_i = 0; bus.bc_ack_i = 0; bus.bc_rdata_i = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.bc_done_i = 1; bus.bc_ack_i = resp_ack; bus.bc_rdata_i = resp_data;
        end
      end
      if (bus.bc_valid_o) begin
        bus.bc_ready_i = (vcnt >= bp_cycles);
        vcnt++;
      end else begin
        bus.bc_ready_i = 0;
        vcnt = 0;
      end
      if (wr_hs && wr_src_q.size() > 0) begin
        void'(wr_src_q.pop_front());
        wdly = 0;
      end
      if (wr_src_q.size() > 0) begin
        if (wdly >= wr_delay) begin
          bus.wr_valid_i = 1; bus.wr_data_i = wr_src_q[0];
        end else begin
          bus.wr_valid_i = 0; wdly++;
        end
      end else begin
        bus.wr_valid_i = 0; wdly = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_vals(input string tag);
    chk(tag, 32'({bus.cmd_ready_o, bus.busy_o, bus.done_o, bus.err_nack_o, bus.rd_valid_o,
                  bus.wr_ready_o, bus.bc_valid_o, bus.bc_last_o, bus.bc_op_o,
                  bus.bc_wdata_o, bus.rd_data_o}),
        32'({1'b1, 7'b0, 2'b00, 8'h00, 8'h00}));
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic rw, input logic [4:0] len);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1; bus.cmd_dev_addr_i = a; bus.cmd_rw_i = rw; bus.cmd_len_i = len;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.cmd_ready_o;
    end
    chk("cmd_accept", 32'(got), 32'(1'b1));
    @(posedge clk); #1;
    bus.cmd_valid_i = 0;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 2000 && n_done == base; i++) @(negedge clk);
    chk("done_seen", 32'(n_done - base), 32'd1);
    chk("ops_left", 32'(exp_op_q.size()), 32'd0);
    chk("rd_left", 32'(exp_rd_q.size()), 32'd0);
  endtask

  // Write 0x50, bytes A5 3C, all ACKed.
  task automatic scen_write_basic();
    int hs0, rdy0, d0;
    exp_op_q.push_back({OP_START, 8'h00, 1'b0});
    exp_op_q.push_back({OP_WRITE, 8'hA0, 1'b0});
    exp_op_q.push_back({OP_WRITE, 8'hA5, 1'b0});
    exp_op_q.push_back({OP_WRITE, 8'h3C, 1'b0});
    exp_op_q.push_back({OP_STOP,  8'h00, 1'b0});
    wr_src_q.push_back(8'hA5);
    wr_src_q.push_back(8'h3C);
    exp_done_q.push_back(1'b0);
    hs0 = n_wr_hs; rdy0 = n_wr_rdy; d0 = n_done;
    send_cmd(7'h50, 1'b0, 5'd2);
    wait_done(d0);
    chk("wr_hs", 32'(n_wr_hs - hs0), 32'd2);
    // With bytes already waiting, each WLOAD visit lasts exactly one cycle.
    if (wr_delay == 0) chk("wr_rdy_cycles", 32'(n_wr_rdy - rdy0), 32'd2);
  endtask

  task automatic push_read3();
    exp_op_q.push_back({OP_START, 8'h00, 1'b0});
    exp_op_q.push_back({OP_WRITE, 8'hD1, 1'b0});
    exp_op_q.push_back({OP_READ,  8'h00, 1'b0});
    exp_op_q.push_back({OP_READ,  8'h00, 1'b0});
    exp_op_q.push_back({OP_READ,  8'h00, 1'b1});
    exp_op_q.push_back({OP_STOP,  8'h00, 1'b0});
    eng_rd_q.push_back(8'h11); eng_rd_q.push_back(8'h22); eng_rd_q.push_back(8'h33);
    exp_rd_q.push_back(8'h11); exp_rd_q.push_back(8'h22); exp_rd_q.push_back(8'h33);
  endtask

  initial begin : main
    int d0, hs0, rdy0, r0;
    bus.cmd_valid_i = 0; bus.cmd_dev_addr_i = 0; bus.cmd_rw_i = 0; bus.cmd_len_i = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset_init");
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk_reset_vals("idle_after_reset");

    // 1: plain write
    scen_write_basic();

    // 2: read 3 bytes
    push_read3();
    exp_done_q.push_back(1'b0);
    hs0 = n_wr_hs; d0 = n_done;
    send_cmd(7'h68, 1'b1, 5'd3);
    wait_done(d0);
    chk("rd_no_wr_hs", 32'(n_wr_hs - hs0), 32'd0);

    // 3: address-only probe, address NACKed
    exp_op_q.push_back({OP_START, 8'h00, 1'b0});
    exp_op_q.push_back({OP_WRITE, 8'hFE, 1'b0});
    exp_op_q.push_back({OP_STOP,  8'h00, 1'b0});
    eng_ack_q.push_back(1'b0);
    exp_done_q.push_back(1'b1);
    rdy0 = n_wr_rdy; d0 = n_done;
    send_cmd(7'h7F, 1'b0, 5'd0);
    wait_done(d0);
    chk("probe_no_wr_rdy", 32'(n_wr_rdy - rdy0), 32'd0);

    // 4: write 3 bytes, second data byte NACKed
    exp_op_q.push_back({OP_START, 8'h00, 1'b0});
    exp_op_q.push_back({OP_WRITE, 8'h54, 1'b0});
    exp_op_q.push_back({OP_WRITE, 8'h01, 1'b0});
    exp_op_q.push_back({OP_WRITE, 8'h02, 1'b0});
    exp_op_q.push_back({OP_STOP,  8'h00, 1'b0});
    eng_ack_q.push_back(1'b1); eng_ack_q.push_back(1'b1); eng_ack_q.push_back(1'b0);
    wr_src_q.push_back(8'h01); wr_src_q.push_back(8'h02); wr_src_q.push_back(8'h03);
    exp_done_q.push_back(1'b1);
    hs0 = n_wr_hs; d0 = n_done;
    send_cmd(7'h2A, 1'b0, 5'd3);
    wait_done(d0);
    chk("nack_wr_hs", 32'(n_wr_hs - hs0), 32'd2);
    chk("nack_src_left", 32'(wr_src_q.size()), 32'd1);
    wr_src_q.delete();
    repeat (2) @(posedge clk);

    // 5: backpressure on every op, write bytes delayed
    bp_cycles = 4; wr_delay = 3;
    scen_write_basic();
    bp_cycles = 0; wr_delay = 0;

    // 6: reset during the wait of the first READ
    push_read3();
    r0 = n_rd_acc; d0 = n_done;
    send_cmd(7'h68, 1'b1, 5'd3);
    for (int i = 0; i < 200 && n_rd_acc == r0; i++) @(negedge clk);
    chk("rd_acc_seen", 32'(n_rd_acc - r0), 32'd1);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    exp_op_q.delete(); exp_rd_q.delete(); eng_rd_q.delete(); exp_done_q.delete();
    @(negedge clk);
    chk_reset_vals("reset_mid");
    repeat (6) @(negedge clk);
    chk("no_done_after_rst", 32'(n_done - d0), 32'd0);
    chk_reset_vals("idle_after_mid_reset");
    scen_write_basic();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
